// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix-keypad scanner.
//   - key_state_t    : event FSM states (IDLE, PRESSED, BLOCKED)
//   - DEF_*          : default parameter values for the scanner
//   - popcount / exactly_one / more_than_one : bitmap population helpers,
//     bitmaps are zero-extended to MAP_W bits by the caller.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    BLOCKED = 2'd2
  } key_state_t;

  localparam int DEF_ROWS         = 4;
  localparam int DEF_COLS         = 3;
  localparam int DEF_SCAN_DIV     = 1000;
  localparam int DEF_DEBOUNCE     = 4;
  localparam int DEF_REPEAT_DELAY = 32;
  localparam int DEF_REPEAT_RATE  = 8;

  // Widest bitmap supported (8 rows x 8 columns).
  localparam int MAP_W = 64;

  function automatic int popcount(input logic [MAP_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAP_W; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic exactly_one(input logic [MAP_W-1:0] v);
    return popcount(v) == 1;
  endfunction

  function automatic logic more_than_one(input logic [MAP_W-1:0] v);
    return popcount(v) > 1;
  endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column scan timing for the keypad scanner.
// Drives one column low at a time for SCAN_DIV cycles each, cycling
// 0..COLS-1, and flags the last dwell cycle of every column (sample) and
// of the last column (frame_end).
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   col_n      : column drive, exactly one bit low
//   col_idx    : index of the column currently driven
//   sample     : high on the last dwell cycle of the current column
//   frame_end  : high on the last dwell cycle of column COLS-1
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  localparam int IW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [COLS-1:0] col_n,
  output logic [IW-1:0]   col_idx,
  output logic            sample,
  output logic            frame_end
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] dwell;

  assign sample    = (dwell == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx == IW'(COLS - 1));
  assign col_n     = ~(COLS'(1) << col_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell   <= '0;
      col_idx <= '0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= (col_idx == IW'(COLS - 1)) ? '0 : col_idx + 1'b1;
    end else begin
      dwell   <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_matrix_scan.sv
// Matrix-keypad scanner: scans columns, samples active-low rows, debounces
// the whole key bitmap frame by frame and emits one binary key code per
// debounced single-key press over a valid/ready handshake.
// Optional feature macro: KEYPAD_REPEAT_EN enables typematic repeat
// (REPEAT_DELAY frames before the first repeat, then every REPEAT_RATE).
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   row_n      : row lines, low = key closed on driven column (async)
//   col_n      : column drive, exactly one bit low
//   key_code   : row*COLS + col of the accepted key
//   key_valid  : key_code valid, held until key_ready
//   key_ready  : consumer accept
//   key_held   : debounced bitmap non-zero
//   overrun    : one-cycle pulse when an event is dropped
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
`endif
  localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overrun
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);

  function automatic logic [CW-1:0] encode(input logic [N-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = N - 1; i >= 0; i--) if (m[i]) c = CW'(i);
    return c;
  endfunction

  logic [IW-1:0]   col_idx;
  logic            sample, frame_end;
  logic [ROWS-1:0] row_n_p0, row_n_p1;
  logic [N-1:0]    frame_acc, frame_prev, frame_now, deb_map;
  logic [SW-1:0]   stab_cnt, stab_nxt;
  logic            deb_load, emit, accept;
  key_state_t      state, state_nxt;
  logic [CW-1:0]   key_code_nxt;
  logic            key_valid_nxt, overrun_nxt;

  keypad_col_scanner #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .col_idx   (col_idx),
    .sample    (sample),
    .frame_end (frame_end)
  );

  // Stage p0/p1: two-flop row synchroniser
  always_ff @(posedge clk) begin
    row_n_p0 <= row_n;
    row_n_p1 <= row_n_p0;
  end

  // Frame assembly: current frame with the driven column's rows patched in,
  // so the frame is complete on the frame_end cycle itself.
  always_comb begin
    frame_now = frame_acc;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (col_idx == IW'(c)) frame_now[r*COLS + c] = ~row_n_p1[r];
  end

  always_comb begin
    if (frame_now != frame_prev)       stab_nxt = SW'(1);
    else if (stab_cnt == SW'(DEBOUNCE)) stab_nxt = stab_cnt;
    else                               stab_nxt = stab_cnt + 1'b1;
  end

  assign deb_load = frame_end && (stab_nxt == SW'(DEBOUNCE));
  assign key_held = |deb_map;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_acc  <= '0;
      frame_prev <= '0;
      stab_cnt   <= '0;
      deb_map    <= '0;
    end else begin
      if (sample) frame_acc <= frame_now;
      if (frame_end) begin
        frame_prev <= frame_now;
        stab_cnt   <= stab_nxt;
      end
      if (deb_load) deb_map <= frame_now;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  logic [RW-1:0] rpt_cnt, rpt_cnt_nxt;
  logic          rpt_armed, rpt_armed_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_armed <= rpt_armed_nxt;
    end
  end
`endif

  // Event FSM and output handshake, evaluated on the bitmap being loaded
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_nxt   = rpt_cnt;
    rpt_armed_nxt = rpt_armed;
`endif
    if (deb_load) begin
      case (state)
        IDLE: begin
          if (exactly_one(MAP_W'(frame_now))) begin
            state_nxt = PRESSED;
            emit      = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_nxt   = '0;
            rpt_armed_nxt = 1'b0;
`endif
          end else if (more_than_one(MAP_W'(frame_now))) begin
            state_nxt = BLOCKED;
          end
        end
        PRESSED: begin
          // Any change other than a full release (extra key, or a
          // different single key) needs a full release before the next event.
          if (frame_now == '0)          state_nxt = IDLE;
          else if (frame_now != deb_map) state_nxt = BLOCKED;
`ifdef KEYPAD_REPEAT_EN
          else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
            if (rpt_cnt_nxt == RW'(rpt_armed ? REPEAT_RATE : REPEAT_DELAY)) begin
              emit          = 1'b1;
              rpt_cnt_nxt   = '0;
              rpt_armed_nxt = 1'b1;
            end
          end
`endif
        end
        BLOCKED: if (frame_now == '0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    accept        = key_valid & key_ready;
    key_valid_nxt = key_valid & ~accept;
    key_code_nxt  = key_code;
    overrun_nxt   = 1'b0;
    if (emit) begin
      if (!key_valid || accept) begin
        key_valid_nxt = 1'b1;
        key_code_nxt  = encode(frame_now);
      end else begin
        overrun_nxt   = 1'b1;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: doc/keypad_matrix_scan.md
# keypad_matrix_scan

Parametrised matrix-keypad scanner that drives columns one at a time, samples active-low row lines, debounces the whole key bitmap and emits one encoded key code per debounced press. It replaces the direct 12-bit one-hot keypad pass-through: downstream display/entry logic consumes a binary key code over a valid/ready handshake instead of raw switch lines.

## Interface
- ROWS, 4: number of row inputs (1..8)
- COLS, 3: number of column drive outputs (1..8)
- SCAN_DIV, 1000: clk cycles each column is driven (≥2)
- DEBOUNCE, 4: consecutive identical frames required to accept a bitmap (≥1)
- CW, $clog2(ROWS*COLS): key code width (localparam)
- Reset is `rst`: asynchronous, active-low. The clock is `clk`.
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- row_n  in  ROWS  row lines, low = key closed on the driven column; asynchronous to clk
- col_n  out  COLS  column drive, exactly one bit low at all times
- key_code  out  CW  code = row*COLS + col of the accepted key
- key_valid  out  1  key_code valid, held until accepted
- key_ready  in  1  consumer accepts when key_valid & key_ready
- key_held  out  1  debounced bitmap non-zero
- overrun  out  1  one-cycle pulse: press event lost because key_valid still pending

## Operation
- row_n passes through a 2-flop synchroniser; all logic uses the synchronised copy.
- Column index cycles 0..COLS-1, wrapping to 0; col_n = ~(1 << index). Dwell counter counts 0..SCAN_DIV-1.
- Rows are sampled on the last dwell cycle, into the bitmap bits for that column (inverted, 1 = pressed).
- Frame end = last dwell cycle of column COLS-1. At frame end, the raw frame is compared with the previous raw frame:
  - Equal: the stable counter increments, saturating at DEBOUNCE.
  - Different: the stable counter resets to 1.
  - When the counter reaches DEBOUNCE, the debounced bitmap is loaded from the frame.
- Event FSM, evaluated when the debounced bitmap updates:
  - IDLE: one bit set → PRESSED, emit event with that code. More than one bit set → BLOCKED. Zero → stay.
  - PRESSED: zero → IDLE. Two or more bits set → BLOCKED. Same single key → stay.
  - BLOCKED: zero → IDLE; otherwise stay. Multi-key chords and ghosting never produce an event; a full release is required before the next event.
- Emit event:
  - If key_valid = 0: load key_code and set key_valid.
  - If key_valid = 1 and not being accepted this cycle: drop the event and pulse overrun.
  - If key_valid = 1 and accepted in the same cycle: load the new code and keep key_valid = 1.
- key_valid clears on handshake unless a new event loads in that same cycle.
- key_held = |debounced bitmap.
- Reset mid-scan:
  - Reset values: index 0, dwell 0, bitmaps 0, stable counter 0, FSM IDLE, col_n = ~1, key_code 0, key_valid 0, key_held 0, overrun 0.
  - Any pending code is lost.

## Timing
- Frame length F = COLS*SCAN_DIV cycles.
- Press to key_valid: between DEBOUNCE*F and (DEBOUNCE+1)*F cycles, plus 2 cycles for the synchroniser and 1 for the register stage.
- key_valid, key_code and key_held update 1 cycle after frame end.
- overrun pulses in that same cycle.
- Release is debounced identically; key_held falls 1 cycle after the accepting frame end.
- key_valid may be held indefinitely. key_ready has no combinational path to any output except the next-cycle key_valid.

## Configuration
- KEYPAD_REPEAT_EN enables typematic repeat:
  - In PRESSED, after REPEAT_DELAY frames (default 32), re-emit the same code every REPEAT_RATE frames (default 8).
  - Repeat events follow the same overrun rules.
  - Both parameters exist only under the macro.
- Without KEYPAD_REPEAT_EN: exactly one event per press; no repeat counters are synthesised.

## Structure
- Shared package keypad_pkg holds:
  - FSM state enum (IDLE, PRESSED, BLOCKED)
  - Popcount-based "exactly one / more than one" helper functions
  - Default parameter constants
- One sub-module, keypad_col_scanner: dwell counter, column index, col_n drive, sample strobe and frame-end strobe.
- Debounce, FSM and handshake stay in the top module.

## Test plan
Bench settings: ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE=2, F=12. The keypad model closes a row when the matching col_n is low.
- Reset mid-frame with a key pressed: all outputs reach their reset values immediately; col_n=3'b110.
- Single key row 2, col 1 held 5 frames, key_ready=1: one key_valid pulse with key_code=7, first rising within 39 cycles; key_held=1; no repeat without the macro.
- Bounce: key toggles every frame for 4 frames, then stable: only one event, code correct, after the stable period.
- Chord: keys 0 and 4 pressed together, then key 0 released while key 4 held, then all released: no event, overrun=0.
- key_ready=0: press key 3, release it, press key 5: key_code stays 3, overrun pulses once; after key_ready=1, key_valid clears.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=2, REPEAT_RATE=1: key 11 held 6 frames → code 11 emitted at the first accept, then again after 2 frames, then every frame thereafter.
